// File: rtl/poly_note_pkg.sv
// Shared constants and helpers for the poly_note_gen square-wave synthesiser.
// Optional decay envelope is enabled by defining ENVELOPE_EN.
package poly_note_pkg;

    localparam int PAN_L     = 0;
    localparam int PAN_R     = 1;
    localparam int AUD_W_DEF = 16;
    localparam int VOL_W_DEF = 4;

    typedef logic signed [AUD_W_DEF-1:0] sample_t;
    typedef logic        [VOL_W_DEF-1:0] level_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

    // STEP = 2^step_shift: leaves headroom so NCH full-volume channels never overflow.
    function automatic int step_shift(input int aud_w, input int vol_w, input int nch);
        return aud_w - 1 - vol_w - clog2(nch);
    endfunction

endpackage

// File: rtl/note_chan.sv
// One synthesiser channel: half-period divider, phase, level and signed sample.
// With ENVELOPE_EN defined the level is loaded on key-on and decays on decay_tick.
module note_chan #(
    parameter int DIV_W     = 22,
    parameter int AUD_W     = 16,
    parameter int VOL_W     = 4,
    parameter int AMP_SHIFT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_on,
    input  logic [DIV_W-1:0]        div,
    input  logic [VOL_W-1:0]        vol,
`ifdef ENVELOPE_EN
    input  logic                    decay_tick,
`endif
    output logic signed [AUD_W-1:0] sample,
    output logic                    active
);

    logic [DIV_W-1:0] cnt;
    logic             ph;
    logic             running;
    logic [VOL_W-1:0] lvl;
    logic [AUD_W-1:0] amp;

    assign running = note_on && (div != '0);

    // NOTE: state registers use non-blocking assignments so every channel and the mixer see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            ph     <= 1'b0;
            active <= 1'b0;
        end else begin
            active <= running;
            if (!running) begin
                cnt <= '0;
                ph  <= 1'b0;
            end else if (cnt >= div) begin
                // >= rather than == so a lowered divider toggles at once instead of wrapping.
                cnt <= '0;
                ph  <= ~ph;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ENVELOPE_EN
    logic             on_d;
    logic             rise;
    logic [VOL_W-1:0] lvl_q;

    assign rise = note_on && !on_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_d  <= 1'b0;
            lvl_q <= '0;
        end else begin
            on_d <= note_on;
            if (rise) begin
                lvl_q <= vol;
            end else if (decay_tick && (lvl_q != '0)) begin
                lvl_q <= lvl_q - 1'b1;
            end
        end
    end

    // The key-on cycle already sounds at the freshly loaded volume.
    assign lvl = rise ? vol : lvl_q;
`else
    assign lvl = vol;
`endif

    assign amp    = AUD_W'(lvl) << AMP_SHIFT;
    assign sample = !running ? '0 : (ph ? $signed(amp) : -$signed(amp));

endmodule

// File: rtl/poly_note_gen.sv
// Multi-channel square-wave note synthesiser with panned, clamped stereo mix.
// Define ENVELOPE_EN to add the shared decay prescaler and per-channel envelopes.
module poly_note_gen
    import poly_note_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DIV_W     = 22,
    parameter int AUD_W     = AUD_W_DEF,
    parameter int VOL_W     = VOL_W_DEF,
    parameter int DECAY_DIV = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          note_on,
    input  logic [NCH*DIV_W-1:0]    note_div,
    input  logic [NCH*VOL_W-1:0]    vol,
    input  logic [NCH*2-1:0]        pan,
    output logic signed [AUD_W-1:0] audio_left,
    output logic signed [AUD_W-1:0] audio_right,
    output logic [NCH-1:0]          active
);

    localparam int AMP_SHIFT = step_shift(AUD_W, VOL_W, NCH);
    localparam logic signed [AUD_W:0] POS_LIM = (AUD_W+1)'((1 << (AUD_W-1)) - 1);
    localparam logic signed [AUD_W:0] NEG_LIM = -POS_LIM;

    if (NCH < 1 || NCH > 8 || (NCH & (NCH - 1)) != 0) begin : g_bad_nch
        $error("poly_note_gen: NCH must be a power of 2 in 1..8");
    end
    if (DECAY_DIV < 1 || AMP_SHIFT < 0) begin : g_bad_cfg
        $error("poly_note_gen: DECAY_DIV must be >= 1 and widths must leave headroom");
    end

`ifdef ENVELOPE_EN
    localparam int PRE_W = (clog2(DECAY_DIV) < 1) ? 1 : clog2(DECAY_DIV);

    logic [PRE_W-1:0] pre_cnt;
    logic             decay_tick;

    assign decay_tick = (pre_cnt == PRE_W'(DECAY_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (decay_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`endif

    logic signed [AUD_W-1:0] samples [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        note_chan #(
            .DIV_W     (DIV_W),
            .AUD_W     (AUD_W),
            .VOL_W     (VOL_W),
            .AMP_SHIFT (AMP_SHIFT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .note_on    (note_on[i]),
            .div        (note_div[i*DIV_W +: DIV_W]),
            .vol        (vol[i*VOL_W +: VOL_W]),
`ifdef ENVELOPE_EN
            .decay_tick (decay_tick),
`endif
            .sample     (samples[i]),
            .active     (active[i])
        );
    end

    function automatic logic signed [AUD_W-1:0] clamp(input logic signed [AUD_W:0] s);
        if (s > POS_LIM) begin
            return POS_LIM[AUD_W-1:0];
        end else if (s < NEG_LIM) begin
            return NEG_LIM[AUD_W-1:0];
        end
        return s[AUD_W-1:0];
    endfunction

    logic signed [AUD_W:0] sum_l;
    logic signed [AUD_W:0] sum_r;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pan[2*i + PAN_L]) sum_l = sum_l + {samples[i][AUD_W-1], samples[i]};
            if (pan[2*i + PAN_R]) sum_r = sum_r + {samples[i][AUD_W-1], samples[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            audio_left  <= clamp(sum_l);
            audio_right <= clamp(sum_r);
        end
    end

endmodule

// File: tb/tb_poly_note_gen.sv
// Self-checking bench for poly_note_gen: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the channel/mix rules.
module tb_poly_note_gen;
    import poly_note_pkg::*;

    localparam int NCH       = 4;
    localparam int DIV_W     = 22;
    localparam int AUD_W     = 16;
    localparam int VOL_W     = 4;
    localparam int DECAY_DIV = 4;
    localparam int STEP      = 512;
    localparam int LIM       = 32767;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NCH-1:0]          note_on;
    logic [NCH*DIV_W-1:0]    note_div;
    logic [NCH*VOL_W-1:0]    vol;
    logic [NCH*2-1:0]        pan;
    logic signed [AUD_W-1:0] audio_left;
    logic signed [AUD_W-1:0] audio_right;
    logic [NCH-1:0]          active;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state: elapsed clocks in the current half-period, phase, level.
    int m_cnt  [NCH];
    bit m_ph   [NCH];
    int m_lvl  [NCH];
    bit m_prev [NCH];
    int m_pre;
    int exp_l;
    int exp_r;
    int exp_act;

    poly_note_gen #(
        .NCH       (NCH),
        .DIV_W     (DIV_W),
        .AUD_W     (AUD_W),
        .VOL_W     (VOL_W),
        .DECAY_DIV (DECAY_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .note_on     (note_on),
        .note_div    (note_div),
        .vol         (vol),
        .pan         (pan),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_ch(input int ch, input bit on, input int d, input int v, input int p);
        note_on[ch]                = on;
        note_div[ch*DIV_W +: DIV_W] = DIV_W'(d);
        vol[ch*VOL_W +: VOL_W]      = VOL_W'(v);
        pan[ch*2 +: 2]              = 2'(p);
    endtask

    task automatic all_off();
        for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1'b0, 0, 0, 0);
    endtask

    function automatic int sat(input int s);
        if (s > LIM) return LIM;
        if (s < -LIM) return -LIM;
        return s;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_cnt[ch]  = 0;
            m_ph[ch]   = 1'b0;
            m_lvl[ch]  = 0;
            m_prev[ch] = 1'b0;
        end
        m_pre   = 0;
        exp_l   = 0;
        exp_r   = 0;
        exp_act = 0;
    endtask

    // Advance one clock: predict from the current inputs, clock, then compare.
    task automatic cycle(input string tag);
        int sl, sr, act;
        bit tick;
        sl   = 0;
        sr   = 0;
        act  = 0;
        tick = (m_pre == DECAY_DIV - 1);
        for (int ch = 0; ch < NCH; ch++) begin
            bit on, run, rise;
            int d, v, p, lvl, s;
            on   = note_on[ch];
            d    = int'(note_div[ch*DIV_W +: DIV_W]);
            v    = int'(vol[ch*VOL_W +: VOL_W]);
            p    = int'(pan[ch*2 +: 2]);
            run  = on && (d != 0);
            rise = on && !m_prev[ch];
`ifdef ENVELOPE_EN
            lvl = rise ? v : m_lvl[ch];
            if (rise) m_lvl[ch] = v;
            else if (tick && m_lvl[ch] > 0) m_lvl[ch] = m_lvl[ch] - 1;
`else
            lvl = v;
`endif
            s = run ? (m_ph[ch] ? lvl * STEP : -(lvl * STEP)) : 0;
            if (p[0]) sl += s;
            if (p[1]) sr += s;
            if (run) act |= (1 << ch);
            if (!run) begin
                m_cnt[ch] = 0;
                m_ph[ch]  = 1'b0;
            end else if (m_cnt[ch] >= d) begin
                m_cnt[ch] = 0;
                m_ph[ch]  = !m_ph[ch];
            end else begin
                m_cnt[ch] = m_cnt[ch] + 1;
            end
            m_prev[ch] = on;
        end
        m_pre   = tick ? 0 : m_pre + 1;
        exp_l   = sat(sl);
        exp_r   = sat(sr);
        exp_act = act;
        @(posedge clk);
        #1;
        check({tag, "_left"},   int'(audio_left),  exp_l);
        check({tag, "_right"},  int'(audio_right), exp_r);
        check({tag, "_active"}, int'(active),      exp_act);
    endtask

    initial begin
        rst = 1'b1;
        all_off();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_left",   int'(audio_left),  0);
        check("reset_right",  int'(audio_right), 0);
        check("reset_active", int'(active),      0);
        rst = 1'b0;
        cycle("idle");

        // Single channel, div=3: four low samples then four high, both sides equal.
        set_ch(0, 1'b1, 3, 15, 3);
        for (int k = 0; k < 16; k++) begin
            cycle("ch0_div3");
            check("ch0_div3_shape_l", int'(audio_left),  (k % 8) < 4 ? -7680 : 7680);
            check("ch0_div3_shape_r", int'(audio_right), (k % 8) < 4 ? -7680 : 7680);
        end
        all_off();
        repeat (2) cycle("gap");

        // Zero divider and released key both stay silent.
        set_ch(1, 1'b1, 0, 15, 3);
        repeat (4) cycle("div0");
        check("div0_active", int'(active[1]), 0);
        check("div0_left",   int'(audio_left), 0);
        set_ch(1, 1'b0, 5, 15, 3);
        repeat (4) cycle("off_div5");
        check("off_div5_right", int'(audio_right), 0);

        // All four channels in lock-step, then ch2 panned hard left.
        for (int ch = 0; ch < NCH; ch++) set_ch(ch, 1'b1, 3, 15, 3);
        for (int k = 0; k < 8; k++) begin
            cycle("all4");
            check("all4_shape", int'(audio_left), (k % 8) < 4 ? -30720 : 30720);
        end
        set_ch(2, 1'b1, 3, 15, 1);
        for (int k = 8; k < 16; k++) begin
            cycle("pan_ch2");
            check("pan_ch2_right", int'(audio_right), (k % 8) < 4 ? -23040 : 23040);
            check("pan_ch2_left",  int'(audio_left),  (k % 8) < 4 ? -30720 : 30720);
        end

        // Asynchronous reset mid-note with outputs nonzero.
        rst = 1'b1;
        #2;
        check("async_rst_left",   int'(audio_left),  0);
        check("async_rst_right",  int'(audio_right), 0);
        check("async_rst_active", int'(active),      0);
        model_reset();
        all_off();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst");

        // Lower the divider below the running count: immediate toggle, then 11-clock halves.
        set_ch(0, 1'b1, 100, 15, 1);
        repeat (50) cycle("div100");
        set_ch(0, 1'b1, 10, 15, 1);
        cycle("div_drop");
        check("div_drop_old_phase", int'(audio_left), -7680);
        for (int k = 0; k < 22; k++) begin
            cycle("div10");
            check("div10_shape", int'(audio_left), k < 11 ? 7680 : -7680);
        end
        all_off();
        repeat (2) cycle("gap");

`ifdef ENVELOPE_EN
        set_ch(0, 1'b1, 1000, 15, 3);
        cycle("env_start");
        check("env_start_level", int'(audio_left), -7680);
        repeat (70) cycle("env_decay");
        check("env_floor", int'(audio_left), 0);
        set_ch(0, 1'b0, 1000, 15, 3);
        cycle("env_off");
        set_ch(0, 1'b1, 1000, 15, 3);
        cycle("env_retrig");
        check("env_retrig_level", int'(audio_left), -7680);
        repeat (10) cycle("env_tail");
        all_off();
        repeat (2) cycle("gap");
`endif

        // Randomized traffic with occasional divider, volume, pan and key changes.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                set_ch($urandom_range(0, NCH - 1), 1'($urandom_range(0, 3) != 0),
                       $urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 3));
            end
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
